// File: rtl/unary_gen_1_14_if.sv
// Handshake and data bundle for the binary-to-unary stream generator.
// The master drives load/start controls; the slave returns the pulse stream and status.
interface unary_gen_1_14_if #(
  parameter int WIDTH = 14
);
  logic             en;
  logic             din;
  logic             din_valid;
  logic             start;
  logic             u_out;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] remaining;

  modport master (
    output en, din, din_valid, start,
    input  u_out, ready, busy, done, remaining
  );

  modport slave (
    input  en, din, din_valid, start,
    output u_out, ready, busy, done, remaining
  );
endinterface

// File: rtl/unary_gen_1_14.sv
// Serial-loaded binary value emitted as N one-cycle-high/one-cycle-low pulses.
// Global enable freezes the whole block; the pulse count is preserved across freezes.
module unary_gen_1_14 #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  unary_gen_1_14_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_EMIT_HI,
    S_EMIT_LO,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] r_remaining;
  logic [CNT_W-1:0] r_bitcnt;
  logic             r_u_out;
  logic             r_done;

  logic             w_last_bit;
  logic             w_accept_bit;
  logic             w_accept_start;

  assign w_last_bit     = (r_bitcnt == LAST_BIT);
  assign w_accept_bit   = bus.en && bus.din_valid &&
                          ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign w_accept_start = bus.en && bus.start && (r_state == S_READY);

  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch is inferred.
    w_next_state = r_state;
    if (bus.en) begin
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (bus.din_valid) begin
            w_next_state = w_last_bit ? S_READY : S_LOAD;
          end
        end
        S_READY: begin
          if (bus.start) begin
            w_next_state = (r_value == '0) ? S_DONE : S_EMIT_HI;
          end
        end
        S_EMIT_HI: w_next_state = S_EMIT_LO;
        S_EMIT_LO: w_next_state = (r_remaining != '0) ? S_EMIT_HI : S_DONE;
        S_DONE:    w_next_state = S_IDLE;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value     <= '0;
      r_remaining <= '0;
      r_bitcnt    <= '0;
    end else begin
      if (w_accept_bit) begin
        r_value[r_bitcnt] <= bus.din;
        r_bitcnt          <= w_last_bit ? '0 : r_bitcnt + CNT_W'(1);
      end
      if (w_accept_start) begin
        r_remaining <= r_value;
      end
      // Decrement on leaving the high phase; the guard keeps the count from wrapping.
      if (bus.en && (r_state == S_EMIT_HI) && (r_remaining != '0)) begin
        r_remaining <= r_remaining - WIDTH'(1);
      end
      if (bus.en && (r_state == S_DONE)) begin
        r_value     <= '0;
        r_remaining <= '0;
      end
    end
  end

  // Outputs are registered off the next state, so a frozen cycle drives both low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_u_out <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_u_out <= bus.en && (w_next_state == S_EMIT_HI);
      r_done  <= bus.en && (w_next_state == S_DONE);
    end
  end

  assign bus.u_out     = r_u_out;
  assign bus.done      = r_done;
  assign bus.ready     = (r_state == S_READY);
  assign bus.busy      = (r_state == S_EMIT_HI) || (r_state == S_EMIT_LO);
  assign bus.remaining = ((r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_READY))
                         ? r_value : r_remaining;

  a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(r_u_out && r_done));
  a_pulse_in_emit: assert property (@(posedge clk) disable iff (rst)
                                    r_u_out |-> (r_state == S_EMIT_HI));

endmodule
